mem_access_unit: RTL and testbench

- EX/MEM stage directly downstream of the ALU.
- Consumes the ALU result as an effective address (or a pass-through value) plus store data and a memory-op code.
- Runs a valid/ready transaction on the data-memory bus.
- Produces aligned, sign/zero-extended writeback data for the WB stage, with timeout-based bus-error detection.

---
 rtl/mem_pkg.sv | 63 ++++++
 rtl/mem_access_unit_load_align.sv | 36 +++
 rtl/mem_access_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared types and op-decode helpers for the mem_access_unit slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Undefined encodings collapse to NONE so they behave as a pass-through.
  function automatic mem_op_e op_sanitize(input logic [3:0] op);
    if (op > 4'd8) return OP_NONE;
    return mem_op_e'(op);
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_e op_size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_unsigned(input mem_op_e op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
// ============================================================================
// Module  : load_align
// Brief   : Selects the addressed byte/half of a read word and extends it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  mem_op_e     op_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_uns;

  assign w_byte = 8'(rdata_i >> {off_i, 3'b000});
  assign w_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign w_uns  = is_unsigned(op_i);

  always_comb begin
    data_o = rdata_i;
    case (op_size(op_i))
      SZ_BYTE: data_o = w_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: data_o = w_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : EX/MEM stage: valid/ready data-memory access with timeout and
//           aligned writeback. Optional macro MISALIGN_TRAP_EN traps misaligned
//           ops instead of masking the low address bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_exmem,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [3:0]  mem_op_in,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_valid,
  output logic        busy,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        req_q, req_d, we_q, we_d, valid_q, valid_d;
  logic        busy_q, busy_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wbd_q, wbd_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [4:0]  wbrd_q, wbrd_d;

  mem_op_e     w_op;
  size_e       w_size;
  logic        w_is_mem, w_misalign;
  logic [31:0] w_eff_addr, w_load_val;
  logic [1:0]  w_off;

  assign w_op       = op_sanitize(mem_op_in);
  assign w_size     = op_size(w_op);
  assign w_is_mem   = (w_op != OP_NONE);
  assign w_misalign = w_is_mem &&
                      (((w_size == SZ_HALF) && alu_result_in[0]) ||
                       ((w_size == SZ_WORD) && (alu_result_in[1:0] != 2'b00)));

`ifdef MISALIGN_TRAP_EN
  assign w_eff_addr = alu_result_in;
`else
  always_comb begin
    w_eff_addr = alu_result_in;
    if (w_size == SZ_HALF) w_eff_addr[0]   = 1'b0;
    if (w_size == SZ_WORD) w_eff_addr[1:0] = 2'b00;
  end
`endif

  assign w_off = w_eff_addr[1:0];

  load_align u_load_align (
    .rdata_i (mem_rdata),
    .off_i   (off_q),
    .op_i    (op_q),
    .data_o  (w_load_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wbd_d   = 32'd0;
    wbrd_d  = 5'd0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tick_exmem) begin
          op_d    = w_op;
          off_d   = w_off;
          rd_d    = rd_in;
          we_d    = is_store(w_op);
          addr_d  = {w_eff_addr[31:2], 2'b00};
          wdata_d = 32'd0;
          wstrb_d = 4'd0;
          if (is_store(w_op)) begin
            case (w_size)
              SZ_BYTE: begin
                wstrb_d = 4'b0001 << w_off;
                wdata_d = {4{store_data_in[7:0]}};
              end
              SZ_HALF: begin
                wstrb_d = 4'b0011 << {w_off[1], 1'b0};
                wdata_d = {2{store_data_in[15:0]}};
              end
              default: begin
                wstrb_d = 4'hF;
                wdata_d = store_data_in;
              end
            endcase
          end
          if (!w_is_mem) begin
            state_d = ST_DONE;
            wbd_d   = alu_result_in;
            wbrd_d  = rd_in;
          end
`ifdef MISALIGN_TRAP_EN
          else if (w_misalign) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            wbd_d   = alu_result_in;
          end
`endif
          else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Ready takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          state_d = ST_DONE;
          if (is_load(op_q)) begin
            wbd_d  = w_load_val;
            wbrd_d = rd_q;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    req_d   = (state_d == ST_ACCESS);
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q    <= OP_NONE;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      wbd_q   <= 32'd0;
      wbrd_q  <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wbd_q   <= wbd_d;
      wbrd_q  <= wbrd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign wb_data   = wbd_q;
  assign wb_rd     = wbrd_q;
  assign wb_valid  = valid_q;
  assign busy      = busy_q;
  assign bus_error = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_exmem = 1'b0;
  logic [31:0] alu_result_in = 32'd0;
  logic [31:0] store_data_in = 32'd0;
  logic [3:0]  mem_op_in = 4'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, mem_we, wb_valid, busy, bus_error;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_exmem    (tick_exmem),
    .alu_result_in (alu_result_in),
    .store_data_in (store_data_in),
    .mem_op_in     (mem_op_in),
    .rd_in         (rd_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_valid      (wb_valid),
    .busy          (busy),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd);
    tick_exmem = 1'b1; mem_op_in = op; alu_result_in = addr;
    store_data_in = sd; rd_in = rd;
    step();
    tick_exmem = 1'b0; mem_op_in = 4'd0; alu_result_in = 32'd0;
  endtask

  initial begin
    step(); step();
    chk("rst_req",   {31'd0, mem_req},  32'd0);
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_err",   {31'd0, bus_error},32'd0);
    chk("rst_addr",  mem_addr,          32'd0);
    chk("rst_wbd",   wb_data,           32'd0);
    rst = 1'b1;
    step();

    // NONE pass-through
    issue(4'd0, 32'h1234_5678, 32'd0, 5'd5);
    chk("none_valid", {31'd0, wb_valid}, 32'd1);
    chk("none_data",  wb_data, 32'h1234_5678);
    chk("none_rd",    {27'd0, wb_rd}, 32'd5);
    chk("none_req",   {31'd0, mem_req}, 32'd0);
    chk("none_busy",  {31'd0, busy}, 32'd1);
    step();
    chk("none_valid_drop", {31'd0, wb_valid}, 32'd0);
    chk("none_idle",  {31'd0, busy}, 32'd0);

    // Undefined opcode behaves as NONE
    issue(4'd12, 32'h0000_0ABC, 32'd0, 5'd6);
    chk("badop_valid", {31'd0, wb_valid}, 32'd1);
    chk("badop_data",  wb_data, 32'h0000_0ABC);
    chk("badop_req",   {31'd0, mem_req}, 32'd0);
    step();

    // LB, sign-extended top byte
    issue(4'd1, 32'h0000_0103, 32'd0, 5'd7);
    chk("lb_req",   {31'd0, mem_req}, 32'd1);
    chk("lb_addr",  mem_addr, 32'h0000_0100);
    chk("lb_we",    {31'd0, mem_we}, 32'd0);
    chk("lb_wstrb", {28'd0, mem_wstrb}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h80FF_0000;
    step();
    mem_ready = 1'b0;
    chk("lb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lb_data",  wb_data, 32'hFFFF_FF80);
    chk("lb_rd",    {27'd0, wb_rd}, 32'd7);
    chk("lb_reqlo", {31'd0, mem_req}, 32'd0);
    chk("lb_err",   {31'd0, bus_error}, 32'd0);
    step();

    // LBU same address
    issue(4'd4, 32'h0000_0103, 32'd0, 5'd8);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("lbu_valid", {31'd0, wb_valid}, 32'd1);
    chk("lbu_data",  wb_data, 32'h0000_0080);
    step();

    // LH upper half, sign-extended
    issue(4'd2, 32'h0000_0602, 32'd0, 5'd10);
    mem_ready = 1'b1; mem_rdata = 32'h8001_1234;
    step();
    mem_ready = 1'b0;
    chk("lh_data", wb_data, 32'hFFFF_8001);
    step();

    // SH with ready on third ACCESS cycle
    issue(4'd7, 32'h0000_0202, 32'hABCD_1234, 5'd9);
    chk("sh_req1",  {31'd0, mem_req}, 32'd1);
    chk("sh_we",    {31'd0, mem_we}, 32'd1);
    chk("sh_addr",  mem_addr, 32'h0000_0200);
    chk("sh_wstrb", {28'd0, mem_wstrb}, 32'h0000_000C);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    step();
    chk("sh_req2",  {31'd0, mem_req}, 32'd1);
    step();
    chk("sh_req3",  {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("sh_valid", {31'd0, wb_valid}, 32'd1);
    chk("sh_reqlo", {31'd0, mem_req}, 32'd0);
    chk("sh_rd",    {27'd0, wb_rd}, 32'd0);
    chk("sh_data",  wb_data, 32'd0);
    step();

    // SB at offset 1
    issue(4'd6, 32'h0000_0701, 32'h0000_00A5, 5'd11);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h0000_0002);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("sb_valid", {31'd0, wb_valid}, 32'd1);
    step();

    // LW timeout (TIMEOUT_CYCLES=4)
    mem_rdata = 32'hDEAD_BEEF;
    issue(4'd3, 32'h0000_0400, 32'd0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("to_novalid%0d", i), {31'd0, wb_valid}, 32'd0);
      step();
    end
    chk("to_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_err",   {31'd0, bus_error}, 32'd1);
    chk("to_data",  wb_data, 32'd0);
    chk("to_rd",    {27'd0, wb_rd}, 32'd0);
    chk("to_reqlo", {31'd0, mem_req}, 32'd0);
    step();
    chk("to_err_drop", {31'd0, bus_error}, 32'd0);

    // Reset in the middle of ACCESS
    issue(4'd3, 32'h0000_0500, 32'd0, 5'd2);
    chk("rs_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    step();
    chk("rs_reqlo",  {31'd0, mem_req}, 32'd0);
    chk("rs_busy",   {31'd0, busy}, 32'd0);
    chk("rs_valid",  {31'd0, wb_valid}, 32'd0);
    rst = 1'b1;
    step();
    chk("rs_valid2", {31'd0, wb_valid}, 32'd0);
    issue(4'd3, 32'h0000_0504, 32'd0, 5'd4);
    chk("rs2_addr", mem_addr, 32'h0000_0504);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ready = 1'b0;
    chk("rs2_valid", {31'd0, wb_valid}, 32'd1);
    chk("rs2_data",  wb_data, 32'hCAFE_F00D);
    chk("rs2_rd",    {27'd0, wb_rd}, 32'd4);
    step();

    // Misaligned LW
    mem_rdata = 32'h1122_3344;
    issue(4'd3, 32'h0000_0301, 32'd0, 5'd12);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req",   {31'd0, mem_req}, 32'd0);
    chk("mis_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_err",   {31'd0, bus_error}, 32'd1);
    chk("mis_data",  wb_data, 32'h0000_0301);
    chk("mis_rd",    {27'd0, wb_rd}, 32'd0);
    step();
`else
    chk("mis_req",   {31'd0, mem_req}, 32'd1);
    chk("mis_addr",  mem_addr, 32'h0000_0300);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("mis_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_err",   {31'd0, bus_error}, 32'd0);
    chk("mis_data",  wb_data, 32'h1122_3344);
    chk("mis_rd",    {27'd0, wb_rd}, 32'd12);
    step();
`endif
    chk("end_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
